board_io_ctrl: RTL
==================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter KEYS_W, default 4, number of push-button inputs.
REQ-002 SHALL have parameter LEDS_W, default 6, number of LED outputs.
REQ-003 SHALL have parameter KEYS_ACTIVE_LOW, default 1, meaning raw key pressed = 0.
REQ-004 SHALL have parameter LEDS_ACTIVE_LOW, default 1, meaning raw LED lit = 0.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the stable-level qualification time (minimum 1).
REQ-006 SHALL have parameter RST_HOLD_CYCLES, default 16, the post-lock reset stretch (minimum 1).
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock. One clock; all logic is in this domain.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port pll_lock_i, input, 1 bit: asynchronous PLL lock flag.
REQ-010 SHALL have port keys_raw_i, input, KEYS_W bits: raw board keys, asynchronous.
REQ-011 SHALL have port leds_i, input, LEDS_W bits: logical LED request, 1 = lit.
REQ-012 SHALL have port keys_o, output, KEYS_W bits: debounced logical key level, 1 = pressed.
REQ-013 SHALL have port keys_pressed_o, output, KEYS_W bits: one-cycle pulse on each debounced press.
REQ-014 SHALL have port keys_released_o, output, KEYS_W bits: one-cycle pulse on each debounced release.
REQ-015 SHALL have port leds_raw_o, output, LEDS_W bits: board-polarity LED drive.
REQ-016 SHALL have port rst_o, output, 1 bit: system reset for downstream logic, active-high.

Function
REQ-017 SHALL pass each key and pll_lock_i through a 2-flop synchronizer, normalising key polarity to logical (1 = pressed).
REQ-018 SHALL give each key a counter of width $clog2(DEBOUNCE_CYCLES+1), cleared whenever the synced level equals the stable level, and incremented otherwise.
REQ-019 SHALL update the stable level and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES; keys_o equals the stable level.
REQ-020 SHALL produce keys_o change latency as follows: a raw change held constant changes keys_o on edge DEBOUNCE_CYCLES+2, counting the first sampling edge as edge 1. Any shorter glitch is discarded with no output change.
REQ-021 SHALL register keys_pressed_o and keys_released_o on the same edge as the keys_o change, each high for exactly one cycle. Keys are independent, so several bits may pulse simultaneously.
REQ-022 SHALL force keys_pressed_o and keys_released_o to 0 while rst_o=1; debouncing continues.
REQ-023 SHALL implement the reset FSM states WAIT_LOCK, HOLD and RUN, with rst_o a flop equal to (next state != RUN).
REQ-024 SHALL, in WAIT_LOCK, move to HOLD with the hold counter at 0 when synced lock=1.
REQ-025 SHALL, in HOLD, increment the hold counter each cycle, move to RUN on the cycle the counter equals RST_HOLD_CYCLES-1, and return to WAIT_LOCK if synced lock=0.
REQ-026 SHALL, in RUN, return to WAIT_LOCK when synced lock=0. Lock loss takes priority over all other transitions.
REQ-027 SHALL register leds_raw_o as leds_i XOR {LEDS_W{LEDS_ACTIVE_LOW}}, driving all LEDs unlit while rst_o=1, with 1-cycle latency.

Reset
REQ-028 SHALL, while rst_i=1, clear immediately, independent of clk_i: synchronizers at inactive level, counters 0, keys_o 0, pulses 0, FSM WAIT_LOCK, rst_o 1, leds_raw_o unlit.
REQ-029 SHALL discard any in-progress debounce or hold count when rst_i asserts mid-operation.

Structure
REQ-030 SHALL place KEYS_W, LEDS_W and the FSM enum type rst_state_t in shared package board_pkg.
REQ-031 SHALL implement the per-key synchronizer, debounce and edge detect as sub-module key_debounce, instantiated KEYS_W times via generate.

Verification (DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, KEYS_W=4, LEDS_W=6, active-low)
REQ-032 SHALL cover reset/no-lock: rst_i pulse with pll_lock_i=0 for 50 cycles -> rst_o=1, keys_o=0, leds_raw_o=6'b111111 throughout.
REQ-033 SHALL cover lock release: pll_lock_i rises before edge 1 -> rst_o falls on edge 11, leds_raw_o follows leds_i=6'b000001 as 6'b111110 one edge later.
REQ-034 SHALL cover clean press: keys_raw_i[2] low for 12 cycles -> keys_o[2] rises on edge 6 with a single keys_pressed_o[2] pulse; release -> one keys_released_o[2] pulse 6 edges later.
REQ-035 SHALL cover bounce rejection: key 0 toggled at 3-cycle intervals for 30 cycles -> keys_o and both pulse buses stay 0.
REQ-036 SHALL cover lock loss: pll_lock_i drops in RUN -> rst_o=1 on edge 3 after, pulses suppressed, LEDs unlit; relock -> rst_o low after 11 more edges.
REQ-037 SHALL cover async reset mid-debounce: rst_i asserted between clock edges at debounce count 3 -> keys_o and counters 0 before the next clk_i edge, with no pulse.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board I/O constants and the reset sequencer state type.
// No logic here; latency and backpressure are not applicable.
package board_pkg;

    localparam int KEYS_W = 4;
    localparam int LEDS_W = 6;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } rst_state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop sync, stable-level debounce, press/release pulse; level changes DEBOUNCE_CYCLES+2 edges after input.
// No backpressure; pulses are dropped (never queued) while suppress_i is high.
module key_debounce #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    input  logic suppress_i,
    output logic key_o,
    output logic pressed_o,
    output logic released_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_log;
    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_q;
    logic             released_q;

    // Polarity is normalised before the synchronizer so its reset value is "not pressed".
    assign key_log = key_raw_i ^ (ACTIVE_LOW != 0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            stable_q   <= 1'b0;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_log};
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q   <= sync_q[1];
                cnt_q      <= '0;
                pressed_q  <= sync_q[1] & ~suppress_i;
                released_q <= ~sync_q[1] & ~suppress_i;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign key_o      = stable_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O: debounced keys with edge pulses, registered LED polarity, PLL-lock reset sequencer.
// LED drive 1 cycle, keys DEBOUNCE_CYCLES+2 cycles; no backpressure, pulses dropped while rst_o is high.
module board_io_ctrl #(
    parameter int KEYS_W          = board_pkg::KEYS_W,
    parameter int LEDS_W          = board_pkg::LEDS_W,
    parameter int KEYS_ACTIVE_LOW = 1,
    parameter int LEDS_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pll_lock_i,
    input  logic [KEYS_W-1:0] keys_raw_i,
    input  logic [LEDS_W-1:0] leds_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] keys_pressed_o,
    output logic [KEYS_W-1:0] keys_released_o,
    output logic [LEDS_W-1:0] leds_raw_o,
    output logic              rst_o
);

    import board_pkg::*;

    localparam int               HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [LEDS_W-1:0] LED_OFF   = {LEDS_W{LEDS_ACTIVE_LOW != 0}};

    rst_state_t        state_q;
    rst_state_t        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [1:0]        lock_sync_q;
    logic              lock_s;
    logic              rst_d;
    logic              rst_q;
    logic [LEDS_W-1:0] leds_q;

    assign lock_s = lock_sync_q[1];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign rst_d = (state_d != RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            state_q     <= WAIT_LOCK;
            hold_q      <= '0;
            rst_q       <= 1'b1;
            leds_q      <= LED_OFF;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_lock_i};
            state_q     <= state_d;
            hold_q      <= hold_d;
            rst_q       <= rst_d;
            // Unlit on the edge reset rises and stay unlit one edge after it falls.
            leds_q      <= (rst_q | rst_d) ? LED_OFF : (leds_i ^ LED_OFF);
        end
    end

    assign rst_o      = rst_q;
    assign leds_raw_o = leds_q;

    for (genvar k = 0; k < KEYS_W; k++) begin : g_keys
        key_debounce #(
            .ACTIVE_LOW      (KEYS_ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .key_raw_i  (keys_raw_i[k]),
            .suppress_i (rst_d),
            .key_o      (keys_o[k]),
            .pressed_o  (keys_pressed_o[k]),
            .released_o (keys_released_o[k])
        );
    end

endmodule
